// File: rtl/redun_chk_arb_2to1.sv
// Two-input round-robin arbiter with a redundancy check in front of one
// message channel. The winner's message is latched, its redundancy is
// recomputed from the latched copy, and the message is either forwarded
// or dropped and counted.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

// Redundancy: XOR-fold of {src,dst,dat} into RSZ-bit chunks, LSB-aligned,
// with the top chunk zero-padded.
module calc_redun #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);
  localparam int MW  = 2*ASZ + DSZ;
  localparam int NCH = (MW + RSZ - 1) / RSZ;

  logic [NCH*RSZ-1:0] pad;

  // Zero-pad the message and fold chunk by chunk.
  always_comb begin
    pad = '0;
    pad[MW-1:0] = {src, dst, dat};
    red = '0;
    for (int c = 0; c < NCH; c++) red = red ^ pad[c*RSZ +: RSZ];
  end
endmodule

module redun_chk_arb_2to1 #(
  parameter int ASZ  = `NS_ADDRESS_SIZE,
  parameter int DSZ  = `NS_DATA_SIZE,
  parameter int RSZ  = `NS_REDUN_SIZE,
  parameter int ECSZ = 8
) (
  input  logic            i_clk,
  input  logic            reset,
  input  logic            i0_req,
  output logic            i0_ack,
  input  logic [ASZ-1:0]  i0_src,
  input  logic [ASZ-1:0]  i0_dst,
  input  logic [DSZ-1:0]  i0_dat,
  input  logic [RSZ-1:0]  i0_red,
  input  logic            i1_req,
  output logic            i1_ack,
  input  logic [ASZ-1:0]  i1_src,
  input  logic [ASZ-1:0]  i1_dst,
  input  logic [DSZ-1:0]  i1_dat,
  input  logic [RSZ-1:0]  i1_red,
  output logic            o_req,
  input  logic            o_ack,
  output logic [ASZ-1:0]  o_src,
  output logic [ASZ-1:0]  o_dst,
  output logic [DSZ-1:0]  o_dat,
  output logic [RSZ-1:0]  o_red,
  output logic            o_err,
  output logic [ECSZ-1:0] o_err_cnt
);
  typedef enum logic [2:0] {IDLE, GET, CHK, SEND, DONE} state_t;

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;     // input currently being served
  logic            last_q, last_d;   // input granted most recently
  logic [ASZ-1:0]  src_q, src_d, dst_q, dst_d;
  logic [DSZ-1:0]  dat_q, dat_d;
  logic [RSZ-1:0]  red_q, red_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic            oreq_q, oreq_d, oerr_q, oerr_d;
  logic [ECSZ-1:0] cnt_q, cnt_d;
  logic [RSZ-1:0]  calc_red;

  // Shared checker sees only the latched copy, so sender data may change
  // freely once the handshake has completed.
  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc (
    .src(src_q), .dst(dst_q), .dat(dat_q), .red(calc_red)
  );

  // Next-state, grant selection, message latch and error counting.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dat_d   = dat_q;
    red_d   = red_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    oreq_d  = oreq_q;
    oerr_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (i0_req || i1_req) begin
        // On a tie the input not served last time wins.
        gnt_d = (i0_req && i1_req) ? ~last_q : i1_req;
        if (gnt_d) begin
          src_d = i1_src; dst_d = i1_dst; dat_d = i1_dat; red_d = i1_red;
        end else begin
          src_d = i0_src; dst_d = i0_dst; dat_d = i0_dat; red_d = i0_red;
        end
        ack0_d  = ~gnt_d;
        ack1_d  = gnt_d;
        state_d = GET;
      end
      GET: if (!(gnt_q ? i1_req : i0_req)) begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        last_d  = gnt_q;
        state_d = CHK;
      end
      CHK: begin
        if (red_q == calc_red) begin
          oreq_d  = 1'b1;
          state_d = SEND;
        end else begin
          oerr_d  = 1'b1;
          if (cnt_q != {ECSZ{1'b1}}) cnt_d = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      SEND: if (o_ack) begin
        oreq_d  = 1'b0;
        state_d = DONE;
      end
      DONE: if (!o_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      src_q   <= '0;
      dst_q   <= '0;
      dat_q   <= '0;
      red_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      oreq_q  <= 1'b0;
      oerr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dat_q   <= dat_d;
      red_q   <= red_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      oreq_q  <= oreq_d;
      oerr_q  <= oerr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign i0_ack    = ack0_q;
  assign i1_ack    = ack1_q;
  assign o_req     = oreq_q;
  assign o_src     = src_q;
  assign o_dst     = dst_q;
  assign o_dat     = dat_q;
  assign o_red     = red_q;
  assign o_err     = oerr_q;
  assign o_err_cnt = cnt_q;
endmodule
